// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: shares one external ALU between two requesters and
// returns each registered result on a single response channel tagged with the requester ID.
module alu_issue_arbiter #(
    parameter int WIDTH = 64,
    parameter int SHW = 6,
    parameter int RR_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SHW-1:0]   req0_shamt,
    input  logic [2:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SHW-1:0]   req1_shamt,
    input  logic [2:0]       req1_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SHW-1:0]   alu_shiftamt,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, nxt;
    logic   ptr, gid, pick1, hs;
    // ptr names the requester favoured on contention; ignored in fixed-priority mode
    assign pick1 = req1_valid && (!req0_valid || ((RR_EN != 0) && ptr));
    always_ff @(posedge clk)
        state <= rst ? IDLE : nxt;
    always_comb
        nxt = state == IDLE ? (hs ? EXEC : IDLE) :
              state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
    always_comb begin
        req0_ready = state == IDLE && req0_valid && !pick1;
        req1_ready = state == IDLE && pick1;
        hs         = req0_ready || req1_ready;
        rsp_valid  = state == RESP;
        busy       = state != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_shiftamt <= '0;
            alu_sel      <= '0;
            rsp_data     <= '0;
            rsp_id       <= 1'b0;
            rsp_err      <= 1'b0;
            gid          <= 1'b0;
            ptr          <= 1'b0;
        end else begin
            if (hs) begin
                alu_a        <= pick1 ? req1_a : req0_a;
                alu_b        <= pick1 ? req1_b : req0_b;
                alu_shiftamt <= pick1 ? req1_shamt : req0_shamt;
                alu_sel      <= pick1 ? req1_sel : req0_sel;
                gid          <= pick1;
                ptr          <= !pick1;
            end
            if (state == EXEC) begin
                rsp_data <= alu_sel == 3'b111 ? '0 : alu_result;
                rsp_err  <= alu_sel == 3'b111;
                rsp_id   <= gid;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: directed scoreboard bench; a round-robin and a fixed-priority
// instance share the same stimulus and each drives its own ALU model.
module tb_alu_issue_arbiter;
    localparam logic [63:0] A = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] B = 64'hBBBB_BBBB_BBBB_BBBB;
    logic clk = 0, rst = 1, rsp_ready = 1;
    logic req0_valid = 0, req1_valid = 0;
    logic [63:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [5:0] req0_shamt = 0, req1_shamt = 0;
    logic [2:0] req0_sel = 0, req1_sel = 0;
    logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, busy;
    logic [63:0] alu_a, alu_b, alu_result, rsp_data;
    logic [5:0] alu_shiftamt;
    logic [2:0] alu_sel;
    logic f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id, f_rsp_err, f_busy;
    logic [63:0] f_alu_a, f_alu_b, f_alu_result, f_rsp_data;
    logic [5:0] f_alu_shiftamt;
    logic [2:0] f_alu_sel;
    int checks = 0, failures = 0;
    logic mptr = 0;
    typedef struct packed {logic id; logic [63:0] data; logic err;} rsp_t;
    rsp_t q[$];

    always #5 clk = ~clk;

    function automatic logic [63:0] alu_f(input logic [63:0] a, b, input logic [5:0] sh, input logic [2:0] sel);
        case (sel)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a | b;
            3'd3: return a ^ b;
            3'd4: return a & b;
            3'd5: return a << sh;
            3'd6: return a >> sh;
            default: return 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    endfunction
    assign alu_result   = alu_f(alu_a, alu_b, alu_shiftamt, alu_sel);
    assign f_alu_result = alu_f(f_alu_a, f_alu_b, f_alu_shiftamt, f_alu_sel);

    alu_issue_arbiter #(.WIDTH(64), .SHW(6), .RR_EN(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_shamt(req0_shamt), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_shamt(req1_shamt), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shiftamt(alu_shiftamt), .alu_sel(alu_sel),
        .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    alu_issue_arbiter #(.WIDTH(64), .SHW(6), .RR_EN(0)) dut_fixed (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_shamt(req0_shamt), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_shamt(req1_shamt), .req1_sel(req1_sel),
        .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_shiftamt(f_alu_shiftamt), .alu_sel(f_alu_sel),
        .alu_result(f_alu_result), .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(f_rsp_id), .rsp_data(f_rsp_data), .rsp_err(f_rsp_err), .busy(f_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic id, input logic [63:0] a, b, input logic [5:0] sh, input logic [2:0] sel);
        if (id) begin
            req1_a = a; req1_b = b; req1_shamt = sh; req1_sel = sel; req1_valid = 1;
        end else begin
            req0_a = a; req0_b = b; req0_shamt = sh; req0_sel = sel; req0_valid = 1;
        end
    endtask

    task automatic pop_check(input string tag);
        rsp_t r;
        check({tag, "_sbq"}, 64'(q.size()), 1);
        r = q.pop_front();
        check({tag, "_id"}, rsp_id, r.id);
        check({tag, "_data"}, rsp_data, r.data);
        check({tag, "_err"}, rsp_err, r.err);
    endtask

    task automatic wait_grant();
        int n = 0;
        #1;
        while (!(req0_ready || req1_ready) && n < 10) begin
            tick();
            n++;
        end
    endtask

    // single requester op; hold>0 applies that many cycles of backpressure in RESP
    task automatic op(input logic id, input logic [63:0] a, b, input logic [5:0] sh,
                      input logic [2:0] sel, input logic [63:0] ed, input logic ee, input int hold);
        drive(id, a, b, sh, sel);
        wait_grant();
        check("grant", id ? req1_ready : req0_ready, 1);
        check("grant_other", id ? req0_ready : req1_ready, 0);
        q.push_back('{id, ed, ee});
        mptr = !id;
        rsp_ready = (hold == 0);
        tick();
        req0_valid = 0; req1_valid = 0; req0_a = ~a; req1_a = ~a;
        check("exec_busy", busy, 1);
        check("exec_rv", rsp_valid, 0);
        tick();
        check("resp_lat", rsp_valid, 1);
        check("alu_a_hold", alu_a, a);
        for (int i = 0; i < hold; i++) begin
            req0_valid = 1; req1_valid = 1;
            #1;
            check("bp_rv", rsp_valid, 1);
            check("bp_data", rsp_data, ed);
            check("bp_id", rsp_id, id);
            check("bp_rdy", {req0_ready, req1_ready}, 0);
            check("bp_busy", busy, 1);
            req0_valid = 0; req1_valid = 0;
            tick();
        end
        rsp_ready = 1;
        #1;
        pop_check("rsp");
        tick();
        check("idle_rv", rsp_valid, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_rv", rsp_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_data", rsp_data, 0);
        check("rst_fbusy", f_busy, 0);
        rst = 0;
        op(0, A, B, 0, 3'b000, 64'h6666_6666_6666_6665, 0, 0);
        op(1, A, B, 0, 3'b001, 64'hEEEE_EEEE_EEEE_EEEF, 0, 0);
        op(1, A, B, 0, 3'b010, 64'hBBBB_BBBB_BBBB_BBBB, 0, 0);
        op(1, A, B, 0, 3'b011, 64'h1111_1111_1111_1111, 0, 0);
        op(1, A, B, 0, 3'b100, 64'hAAAA_AAAA_AAAA_AAAA, 0, 0);
        op(0, A, B, 0, 3'b111, 64'h0, 1, 0);
        op(0, A, B, 0, 3'b000, 64'h6666_6666_6666_6665, 0, 0);
        op(1, A, B, 0, 3'b011, 64'h1111_1111_1111_1111, 0, 5);
        op(0, A, B, 4, 3'b101, 64'hAAAA_AAAA_AAAA_AAA0, 0, 0);
        // contention from a freshly reset pointer
        rst = 1; tick(); rst = 0; mptr = 0;
        drive(0, 64'd1, 64'd2, 0, 3'b000);
        drive(1, 64'd10, 64'd20, 0, 3'b000);
        for (int k = 0; k < 4; k++) begin
            wait_grant();
            check("rr_gnt1", req1_ready, mptr);
            check("rr_gnt0", req0_ready, !mptr);
            check("fx_gnt0", f_req0_ready, 1);
            q.push_back('{mptr, mptr ? 64'd30 : 64'd3, 1'b0});
            mptr = !mptr;
            tick(); tick();
            check("fx_id", f_rsp_id, 0);
            check("fx_data", f_rsp_data, 3);
            pop_check("rr");
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        tick();
        // reset while an op is in EXEC drops it
        drive(0, A, B, 0, 3'b000);
        wait_grant();
        check("mid_gnt", req0_ready, 1);
        tick();
        check("mid_exec", busy, 1);
        req1_valid = 1;
        rst = 1;
        tick();
        check("mid_busy", busy, 0);
        check("mid_rv", rsp_valid, 0);
        check("mid_alu_a", alu_a, 0);
        check("mid_alu_sel", alu_sel, 0);
        check("mid_data", rsp_data, 0);
        check("mid_id", rsp_id, 0);
        check("mid_err", rsp_err, 0);
        rst = 0;
        #1;
        check("post_gnt0", req0_ready, 1);
        check("post_gnt1", req1_ready, 0);
        req0_valid = 0; req1_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drop_rv", rsp_valid, 0);
        end
        check("drop_sbq", 64'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares one alu_8op instance (64-bit A/B, 6-bit Shiftamt, 3-bit Sel, combinational Output) between two requesters, for example the EX stage and a branch/address helper unit.
- Arbitrates requests, registers operands into the ALU, captures the ALU result and returns it on a single response channel tagged with the requester ID.
- Sits between the pipeline requesters and the ALU. The ALU itself is instantiated outside this block.

Parameters:
- WIDTH, 64, operand/result width (must match the ALU)
- SHW, 6, shift-amount width
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, req0 always wins

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  WIDTH  operand A
- req0_b  in  WIDTH  operand B
- req0_shamt  in  SHW  shift amount
- req0_sel  in  3  ALU op select
- req1_valid / req1_ready / req1_a / req1_b / req1_shamt / req1_sel  same as requester 0, for requester 1
- alu_a  out  WIDTH  to ALU A
- alu_b  out  WIDTH  to ALU B
- alu_shiftamt  out  SHW  to ALU Shiftamt
- alu_sel  out  3  to ALU Sel
- alu_result  in  WIDTH  from ALU Output
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued this response
- rsp_data  out  WIDTH  ALU result
- rsp_err  out  1  Sel was 3'b111 (unsupported op)
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock domain, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- States:
  - IDLE: waiting for a request.
  - EXEC: operands held on the alu_* ports while the ALU evaluates.
  - RESP: rsp_valid is held.
- Reset: state=IDLE; alu_a/alu_b/alu_shiftamt/alu_sel=0; rsp_valid=0; rsp_data=0; rsp_id=0; rsp_err=0; RR pointer=0 (req0 preferred); busy=0. A reset during EXEC or RESP drops the in-flight operation, and no response is produced.
- IDLE:
  - Grant logic is combinational from req0_valid, req1_valid and the pointer.
  - reqN_ready=1 only in IDLE, only for the granted N.
  - If only one requester is valid, it is granted.
  - If both are valid, the pointer's favoured requester wins (RR_EN=1), or req0 wins (RR_EN=0).
  - On handshake (valid&ready): register a/b/shamt/sel onto the alu_* ports, latch the grant ID, go to EXEC.
  - RR pointer update (RR_EN=1): the pointer moves to the non-granted requester.
- EXEC (exactly 1 cycle):
  - At the end of the cycle, capture rsp_data = alu_result, or 0 if alu_sel==3'b111.
  - Capture rsp_err = (alu_sel==3'b111) and rsp_id = latched ID.
  - Go to RESP.
- RESP:
  - rsp_valid=1. rsp_data/rsp_id/rsp_err stay stable until rsp_valid&rsp_ready.
  - On handshake, go to IDLE; rsp_valid drops the next cycle.
  - No new request is accepted in RESP (no bypass).
- Operand hold: alu_* ports hold their last value outside EXEC. They are not cleared, so no spurious toggling.
- Latency: request handshake at edge N, then rsp_valid=1 from cycle N+2. With rsp_ready held at 1, minimum issue interval is 3 cycles per operation.
- Fairness: with both requesters continuously valid and RR_EN=1, grants alternate 0,1,0,1.
- Request inputs are sampled only on the handshake cycle. Requester values may change afterward without effect.
- A request withdrawn before being granted is legal and leaves no state behind.

Test Plan:
- Single op, req0: a=AAAA_AAAA_AAAA_AAAA, b=BBBB_BBBB_BBBB_BBBB, sel=000 → req0_ready in IDLE; rsp_valid 2 cycles after handshake; rsp_data=6666_6666_6666_6665, rsp_id=0, rsp_err=0.
- Ops from req1 with the same operands, in sequence:
  - sel=001 → rsp_data=EEEE_EEEE_EEEE_EEEF
  - sel=010 → BBBB_BBBB_BBBB_BBBB
  - sel=011 → 1111_1111_1111_1111
  - sel=100 → AAAA_AAAA_AAAA_AAAA
  - every response has rsp_id=1.
- Contention, RR_EN=1: req0 and req1 valid for 4 ops → rsp_id sequence 0,1,0,1. Repeat with RR_EN=0 → 0,0,0,0 while req0 stays valid.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid/rsp_data/rsp_id stable; both reqN_ready=0 and busy=1 throughout; IDLE entered the cycle after rsp_ready=1.
- Invalid op: sel=111 → rsp_err=1, rsp_data=0; the next sel=000 op has rsp_err=0.
- Reset mid-op: assert rst in EXEC → next cycle state IDLE, rsp_valid=0, busy=0, all outputs at reset values; no response for the dropped op. The first request after reset is granted to req0 when both are valid.
